// File: rtl/tx_frame_streamer.sv
// Reads one frame from tx_buffer and streams it to the Ethernet MAC over AXI4-Stream.
// Zero-pads short frames to MIN_LEN and inserts an idle gap of IFG cycles after each frame.
module tx_frame_streamer #(
    parameter int unsigned SIZE    = 2048,
    parameter int unsigned LEN_W   = $clog2(SIZE),
    parameter int unsigned MIN_LEN = 60,
    parameter int unsigned IFG     = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_start,
    input  logic [LEN_W-1:0] tx_len,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_len_err,
    output logic             tx_underrun,
    input  logic             btx_empty,
    output logic             btx_rd_en,
    input  logic [7:0]       btx_data,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready
);
    localparam int unsigned GAP_W = (IFG > 1) ? $clog2(IFG) : 1;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_PAD, S_GAP} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] req_cnt_q, req_cnt_d;
    logic [LEN_W-1:0] out_cnt_q, out_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             armed_q, armed_d;
    logic             len_err_q, len_err_d;

    logic [7:0]       fifo_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       fifo_cnt_q;
    logic             inflight_q;

    logic fifo_ne, pop, push, credit_ok, len_short, last_data, last_pad, underrun_cond, len_ok;

    assign fifo_ne   = (fifo_cnt_q != 2'd0);
    assign push      = inflight_q;
    assign pop       = (state_q == S_STREAM) && fifo_ne && m_axis_tready;
    // A pop in the same cycle frees a slot, so the FIFO can sustain one byte per cycle.
    assign credit_ok = (3'({1'b0, fifo_cnt_q}) + 3'(inflight_q) - 3'(pop)) < 3'd2;
    assign len_short = 32'(len_q) < MIN_LEN;
    assign last_data = (out_cnt_q == len_q - LEN_W'(1));
    assign last_pad  = (out_cnt_q == LEN_W'(MIN_LEN - 1));
    assign len_ok    = (tx_len != '0) && (32'(tx_len) < SIZE);

    assign btx_rd_en = (state_q == S_STREAM) && !btx_empty && (req_cnt_q < len_q) && credit_ok;

    assign underrun_cond = (state_q == S_STREAM) && !fifo_ne && !inflight_q
                           && (req_cnt_q < len_q) && !btx_rd_en;

    assign m_axis_tvalid = ((state_q == S_STREAM) && fifo_ne) || (state_q == S_PAD);
    assign m_axis_tdata  = ((state_q == S_STREAM) && fifo_ne) ? fifo_q[rd_ptr_q] : 8'h00;
    assign m_axis_tlast  = ((state_q == S_STREAM) && fifo_ne && last_data && !len_short)
                           || ((state_q == S_PAD) && last_pad);

    assign tx_busy     = (state_q != S_IDLE);
    assign tx_done     = (state_q == S_GAP) && (gap_cnt_q == GAP_W'(IFG - 1));
    assign tx_len_err  = len_err_q;
    assign tx_underrun = underrun_cond && armed_q;

    // Skid FIFO absorbing the buffer read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0]  <= 8'h00;
            fifo_q[1]  <= 8'h00;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= btx_rd_en;
            if (push) begin
                fifo_q[wr_ptr_q] <= btx_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            req_cnt_q <= '0;
            out_cnt_q <= '0;
            gap_cnt_q <= '0;
            armed_q   <= 1'b1;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            req_cnt_q <= req_cnt_d;
            out_cnt_q <= out_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            armed_q   <= armed_d;
            len_err_q <= len_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        req_cnt_d = req_cnt_q + LEN_W'(btx_rd_en);
        out_cnt_d = out_cnt_q;
        gap_cnt_d = gap_cnt_q;
        len_err_d = 1'b0;
        armed_d   = m_axis_tvalid ? 1'b1 : (underrun_cond ? 1'b0 : armed_q);
        unique case (state_q)
            S_IDLE: begin
                armed_d = 1'b1;
                if (tx_start) begin
                    if (len_ok) begin
                        len_d     = tx_len;
                        req_cnt_d = '0;
                        out_cnt_d = '0;
                        state_d   = S_STREAM;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (pop) begin
                    out_cnt_d = out_cnt_q + LEN_W'(1);
                    if (last_data) begin
                        gap_cnt_d = '0;
                        state_d   = len_short ? S_PAD : S_GAP;
                    end
                end
            end
            S_PAD: begin
                if (m_axis_tready) begin
                    out_cnt_d = out_cnt_q + LEN_W'(1);
                    if (last_pad) begin
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_cnt_q == GAP_W'(IFG - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tx_frame_streamer.sv
// Directed bench for tx_frame_streamer: behavioural tx_buffer, beat logger and checks
// of data, tlast placement, padding, backpressure, underrun, length errors and reset.
module tb_tx_frame_streamer;
    localparam int unsigned LEN_W = 11;
    localparam int unsigned SIZE  = 2048;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tx_start = 1'b0;
    logic [LEN_W-1:0] tx_len = '0;
    logic             tx_busy, tx_done, tx_len_err, tx_underrun;
    logic             btx_empty, btx_rd_en;
    logic [7:0]       btx_data = 8'h00;
    logic [7:0]       m_axis_tdata;
    logic             m_axis_tvalid, m_axis_tlast;
    logic             m_axis_tready = 1'b1;

    tx_frame_streamer dut (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_len(tx_len),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_len_err(tx_len_err), .tx_underrun(tx_underrun),
        .btx_empty(btx_empty), .btx_rd_en(btx_rd_en), .btx_data(btx_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
    );

    always #5 clk = ~clk;

    // Behavioural tx_buffer with one-cycle read latency
    logic [7:0] mem [256];
    int rd_ptr = 0, wr_ptr = 0, rd_total = 0, cyc = 0, tr_mode = 0;
    assign btx_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (btx_rd_en) begin
            btx_data <= mem[rd_ptr % 256];
            rd_ptr   <= rd_ptr + 1;
            rd_total <= rd_total + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        m_axis_tready = (tr_mode == 1) ? ((cyc % 2) == 0) : 1'b1;
    end

    // Beat logger
    logic [7:0] bq_data [$];
    logic       bq_last [$];
    int         bq_cyc  [$];
    int done_cnt = 0, done_cyc = 0, und_cnt = 0, err_cnt = 0, stall_bad = 0, rd_bad = 0;
    logic       hold_v = 1'b0, hold_l = 1'b0;
    logic [7:0] hold_d = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_axis_tvalid && m_axis_tready) begin
                bq_data.push_back(m_axis_tdata);
                bq_last.push_back(m_axis_tlast);
                bq_cyc.push_back(cyc);
            end
            if (hold_v && (!m_axis_tvalid || m_axis_tdata != hold_d || m_axis_tlast != hold_l))
                stall_bad++;
            hold_v = m_axis_tvalid && !m_axis_tready;
            hold_d = m_axis_tdata;
            hold_l = m_axis_tlast;
            if (tx_done) begin done_cnt++; done_cyc = cyc; end
            if (tx_underrun) und_cnt++;
            if (tx_len_err) err_cnt++;
            if (btx_rd_en && btx_empty) rd_bad++;
        end else begin
            hold_v = 1'b0;
        end
    end

    int n_vec = 0, n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 256] = base + 8'(i);
            wr_ptr++;
        end
    endtask

    task automatic start(input int len, output int s_cyc);
        tx_start = 1'b1;
        tx_len   = LEN_W'(len);
        s_cyc    = cyc + 1;
        tick(1);
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick(1);
            n++;
        end
        check_eq(tag, 32'(done_cnt - d0), 32'd1);
        tick(2);
    endtask

    // Beat-by-beat data and tlast check for one frame
    task automatic check_frame(input string tag, input int b0, input int nbeats,
                               input int ndata, input logic [7:0] base);
        int got_n = bq_data.size() - b0;
        int lim   = (got_n < nbeats) ? got_n : nbeats;
        check_eq({tag, "_beats"}, 32'(got_n), 32'(nbeats));
        for (int i = 0; i < lim; i++) begin
            logic [7:0] exp_d = (i < ndata) ? base + 8'(i) : 8'h00;
            check_eq($sformatf("%s_data%0d", tag, i), 32'(bq_data[b0 + i]), 32'(exp_d));
            check_eq($sformatf("%s_last%0d", tag, i), 32'(bq_last[b0 + i]), 32'(i == nbeats - 1));
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata, btx_rd_en,
                    tx_busy, tx_done, tx_underrun, tx_len_err});
    endfunction

    initial begin
        int b0, r0, u0, e0, s_cyc, n, max_out, d;

        // Reset state
        tick(3);
        check_eq("reset_outputs", out_vec(), 32'd0);
        rst_n = 1'b1;
        tick(2);
        check_eq("idle_outputs", out_vec(), 32'd0);

        // 1: 64-byte frame at full rate
        b0 = bq_data.size(); r0 = rd_total; u0 = und_cnt;
        load(8'h00, 64);
        start(64, s_cyc);
        wait_done("t1_done", 200);
        check_frame("t1", b0, 64, 64, 8'h00);
        if (bq_data.size() - b0 >= 64) begin
            check_eq("t1_first_valid", 32'(bq_cyc[b0] - s_cyc), 32'd2);
            check_eq("t1_back_to_back", 32'(bq_cyc[b0 + 63] - bq_cyc[b0]), 32'd63);
            check_eq("t1_done_gap", 32'(done_cyc - bq_cyc[b0 + 63]), 32'd12);
        end
        check_eq("t1_reads", 32'(rd_total - r0), 32'd64);
        check_eq("t1_no_underrun", 32'(und_cnt - u0), 32'd0);

        // 2: short frame, padded to 60
        b0 = bq_data.size(); r0 = rd_total;
        load(8'hA0, 10);
        start(10, s_cyc);
        wait_done("t2_done", 200);
        check_frame("t2", b0, 60, 10, 8'hA0);
        check_eq("t2_reads", 32'(rd_total - r0), 32'd10);

        // 3: 100 bytes with tready toggling every cycle
        b0 = bq_data.size(); r0 = rd_total; d = done_cnt; max_out = 0; n = 0;
        load(8'h10, 100);
        tr_mode = 1;
        start(100, s_cyc);
        while (done_cnt == d && n < 600) begin
            int nb = bq_data.size() - b0;
            int o  = (rd_total - r0) - ((nb < 100) ? nb : 100);
            if (o > max_out) max_out = o;
            tick(1);
            n++;
        end
        tr_mode = 0;
        check_eq("t3_done", 32'(done_cnt - d), 32'd1);
        tick(2);
        check_frame("t3", b0, 100, 100, 8'h10);
        check_eq("t3_stall_stable", 32'(stall_bad), 32'd0);
        check_eq("t3_outstanding_le2", 32'(max_out <= 2), 32'd1);
        check_eq("t3_reads", 32'(rd_total - r0), 32'd100);

        // 4: buffer runs dry after 20 of 80 bytes
        b0 = bq_data.size(); u0 = und_cnt;
        load(8'h80, 20);
        start(80, s_cyc);
        tick(29);
        check_eq("t4_stalled_beats", 32'(bq_data.size() - b0), 32'd20);
        check_eq("t4_tvalid_low", 32'(m_axis_tvalid), 32'd0);
        check_eq("t4_busy", 32'(tx_busy), 32'd1);
        load(8'h94, 60);
        wait_done("t4_done", 300);
        check_frame("t4", b0, 80, 80, 8'h80);
        check_eq("t4_underrun_once", 32'(und_cnt - u0), 32'd1);

        // 5: rejected lengths
        r0 = rd_total; e0 = err_cnt;
        start(0, s_cyc);
        tick(2);
        check_eq("t5_err_len0", 32'(err_cnt - e0), 32'd1);
        check_eq("t5_busy_len0", 32'(tx_busy), 32'd0);
        start(int'(SIZE), s_cyc);
        tick(2);
        check_eq("t5_err_lenmax", 32'(err_cnt - e0), 32'd2);
        check_eq("t5_busy_lenmax", 32'(tx_busy), 32'd0);
        check_eq("t5_no_reads", 32'(rd_total - r0), 32'd0);

        // 6: reset mid-frame, then a fresh short frame
        b0 = bq_data.size(); n = 0;
        load(8'h20, 64);
        start(64, s_cyc);
        while (bq_data.size() - b0 < 30 && n < 100) begin
            tick(1);
            n++;
        end
        check_eq("t6_reached_beat30", 32'(bq_data.size() - b0 >= 30), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_reset_outputs", out_vec(), 32'd0);
        tick(2);
        rst_n = 1'b1;
        wr_ptr = rd_ptr;
        tick(1);
        b0 = bq_data.size();
        load(8'hC0, 5);
        start(5, s_cyc);
        wait_done("t6_done", 200);
        check_frame("t6", b0, 60, 5, 8'hC0);
        check_eq("no_read_when_empty", 32'(rd_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
